// File: rtl/cos_ctrl.sv
// Control FSM for the cosine series-evaluation datapath: sequences load,
// multiply and accumulate strobes per term and terminates on TLTY or MAX_TERMS.
module cos_ctrl #(
    parameter int MAX_TERMS = 6,
    parameter int ITW       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic TLTY,
    input  logic repcnt0,
    output logic busy,
    output logic done,
    output logic ld0cnt,
    output logic inccnt,
    output logic rsel,
    output logic xsel,
    output logic ldx,
    output logic ldt,
    output logic ld1,
    output logic ldr,
    output logic en,
    output logic addsub
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MULX1 = 3'd2,
        S_MULX2 = 3'd3,
        S_MULC  = 3'd4,
        S_ACC   = 3'd5,
        S_CHECK = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // acc marks the ACC state so addsub can be formed from the live repcnt0
    typedef struct packed {
        logic busy;
        logic done;
        logic ld0cnt;
        logic inccnt;
        logic rsel;
        logic xsel;
        logic ldx;
        logic ldt;
        logic ld1;
        logic ldr;
        logic en;
        logic acc;
    } strb_t;

    localparam logic [ITW-1:0] MAX_CNT = ITW'(MAX_TERMS);

    function automatic strb_t decode(input state_t s);
        strb_t r;
        r = '0;
        case (s)
            S_IDLE: r = '0;
            S_LOAD: begin
                r.busy   = 1'b1;
                r.ldx    = 1'b1;
                r.ld1    = 1'b1;
                r.ld0cnt = 1'b1;
            end
            S_MULX1, S_MULX2: begin
                r.busy = 1'b1;
                r.xsel = 1'b1;
                r.ldt  = 1'b1;
            end
            S_MULC: begin
                r.busy   = 1'b1;
                r.rsel   = 1'b1;
                r.ldt    = 1'b1;
                r.inccnt = 1'b1;
            end
            S_ACC: begin
                r.busy = 1'b1;
                r.en   = 1'b1;
                r.ldr  = 1'b1;
                r.acc  = 1'b1;
            end
            S_CHECK: r.busy = 1'b1;
            S_DONE:  r.done = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [ITW-1:0] term_cnt_q, term_cnt_d;
    strb_t          strb_q, strb_d;

    // Next-state, term counter and next-output decode
    always_comb begin
        state_d    = state_q;
        term_cnt_d = term_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                term_cnt_d = '0;
                state_d    = S_MULX1;
            end
            S_MULX1: state_d = S_MULX2;
            S_MULX2: state_d = S_MULC;
            S_MULC: begin
                if (term_cnt_q != MAX_CNT) begin
                    term_cnt_d = term_cnt_q + ITW'(1);
                end else begin
                    term_cnt_d = term_cnt_q;
                end
                state_d = S_ACC;
            end
            S_ACC: state_d = S_CHECK;
            S_CHECK: begin
                if (!TLTY) begin
                    state_d = S_DONE;
                end else if (term_cnt_q == MAX_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULX1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they track state_q exactly
        strb_d = decode(state_d);
    end

    // State, term counter and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            term_cnt_q <= '0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            term_cnt_q <= term_cnt_d;
            strb_q     <= strb_d;
        end
    end

    assign busy   = strb_q.busy;
    assign done   = strb_q.done;
    assign ld0cnt = strb_q.ld0cnt;
    assign inccnt = strb_q.inccnt;
    assign rsel   = strb_q.rsel;
    assign xsel   = strb_q.xsel;
    assign ldx    = strb_q.ldx;
    assign ldt    = strb_q.ldt;
    assign ld1    = strb_q.ld1;
    assign ldr    = strb_q.ldr;
    assign en     = strb_q.en;
    // First accumulated term has repcnt=1 and is subtracted
    assign addsub = strb_q.acc & ~repcnt0;

endmodule

// File: tb/tb_cos_ctrl.sv
// Directed bench for cos_ctrl: per-cycle strobe trace, addsub sign sequence,
// termination latency, start-while-busy and asynchronous reset behaviour.
module tb_cos_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic tlty = 1'b0;
    logic repcnt0;
    logic busy, done, ld0cnt, inccnt, rsel, xsel, ldx, ldt, ld1, ldr, en, addsub;

    logic [3:0] coef_q;
    int total = 0;
    int bad = 0;
    int ldr_cnt;
    int inc_cnt;

    always #5 clk = ~clk;

    cos_ctrl #(.MAX_TERMS(6), .ITW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .TLTY(tlty), .repcnt0(repcnt0),
        .busy(busy), .done(done), .ld0cnt(ld0cnt), .inccnt(inccnt),
        .rsel(rsel), .xsel(xsel), .ldx(ldx), .ldt(ldt), .ld1(ld1),
        .ldr(ldr), .en(en), .addsub(addsub)
    );

    // Datapath coefficient counter model feeding repcnt0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_q <= 4'd0;
        end else if (ld0cnt) begin
            coef_q <= 4'd0;
        end else if (inccnt) begin
            coef_q <= coef_q + 4'd1;
        end
    end
    assign repcnt0 = coef_q[0];

    wire [10:0] outvec = {busy, done, ld0cnt, inccnt, rsel, xsel, ldx, ldt, ld1, ldr, en};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected {busy,done,ld0cnt,inccnt,rsel,xsel,ldx,ldt,ld1,ldr,en} at cycle c (LOAD = 1)
    function automatic logic [10:0] exp_vec(input int c, input int n);
        int ph;
        if (c == 1) return 11'b1_0_1_0_0_0_1_0_1_0_0;
        if (c == 5*n + 2) return 11'b0_1_0_0_0_0_0_0_0_0_0;
        if (c < 2 || c > 5*n + 2) return 11'b0;
        ph = (c - 2) % 5;
        case (ph)
            0, 1: return 11'b1_0_0_0_0_1_0_1_0_0_0;
            2:    return 11'b1_0_0_1_1_0_0_1_0_0_0;
            3:    return 11'b1_0_0_0_0_0_0_0_0_1_1;
            default: return 11'b1_0_0_0_0_0_0_0_0_0_0;
        endcase
    endfunction

    task automatic step(input int c, input int n, input int nkeep);
        check_val($sformatf("vec_c%0d", c), 32'(outvec), 32'(exp_vec(c, n)));
        check_val($sformatf("addsub_c%0d", c), 32'(addsub),
                  (ldr === 1'b1) ? 32'(ldr_cnt % 2) : 32'd0);
        if (ldr === 1'b1) ldr_cnt++;
        if (inccnt === 1'b1) inc_cnt++;
        tlty = (ldr_cnt < nkeep);
    endtask

    // Caller sits at a negedge with the DUT in IDLE
    task automatic run_eval(input int n, input int nkeep, input bit hold);
        ldr_cnt = 0;
        inc_cnt = 0;
        tlty = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 5*n + 2; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            step(c, n, nkeep);
        end
        if (hold) begin
            @(negedge clk);
            check_val("idle_gap", 32'(outvec), 32'd0);
            @(negedge clk);
            start = 1'b0;
            ldr_cnt = 0;
            inc_cnt = 0;
            step(1, n, nkeep);
            for (int c = 2; c <= 5*n + 2; c++) begin
                @(negedge clk);
                step(c, n, nkeep);
            end
        end
        check_val("ldr_pulses", 32'(ldr_cnt), 32'(n));
        check_val("inc_pulses", 32'(inc_cnt), 32'(n));
        @(negedge clk);
        check_val("idle_after", 32'(outvec), 32'd0);
    endtask

    initial begin
        // Reset held with start high
        rst = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_hold", 32'({outvec, addsub}), 32'd0);
        end
        rst = 1'b1;
        run_eval(1, 1, 1'b0);

        // Max terms: TLTY stays high
        run_eval(6, 100, 1'b0);

        // Early exit on the third CHECK
        run_eval(3, 3, 1'b0);

        // Start held through a run
        run_eval(1, 1, 1'b1);

        // Reset during MULC of term 2 (cycle 9)
        ldr_cnt = 0;
        inc_cnt = 0;
        tlty = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            step(c, 6, 100);
        end
        #1 rst = 1'b0;
        #1 check_val("rst_async", 32'({outvec, addsub}), 32'd0);
        @(negedge clk);
        check_val("rst_mid_hold", 32'({outvec, addsub}), 32'd0);
        @(negedge clk);
        check_val("rst_mid_hold2", 32'({outvec, addsub}), 32'd0);
        rst = 1'b1;
        // Full six-term run proves the term counter restarted from zero
        run_eval(6, 100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cos_ctrl.md
Name: cos_ctrl

Overview:
- Control unit for the cosine series-evaluation datapath.
- Accepts a start/done handshake from the host side.
- Sequences the datapath load, multiply and accumulate strobes per series term.
- Consumes the datapath status flags (TLTY, repcnt0) to choose add/subtract and to decide termination.

Parameters:
MAX_TERMS, 6, maximum series terms accumulated before forced termination (1..7)
ITW, 3, width of the internal term counter (must hold MAX_TERMS)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a new evaluation; sampled only in IDLE
TLTY  input  1  datapath threshold flag: 1 = current term >= threshold y (keep iterating), 0 = term below y
repcnt0  input  1  LSB of datapath coefficient counter; selects term sign
busy  output  1  high from LOAD through CHECK inclusive
done  output  1  one-cycle pulse in DONE; datapath z is valid this cycle
ld0cnt  output  1  clear datapath coefficient counter
inccnt  output  1  advance datapath coefficient counter
rsel  output  1  multiplier operand = coefficient constant
xsel  output  1  multiplier operand = x register (when rsel=0)
ldx  output  1  load x register from xin
ldt  output  1  load term register with product
ld1  output  1  preset term and result registers to 1.0 (0x0100)
ldr  output  1  load result register from add/sub bus
en  output  1  enable add/sub bus
addsub  output  1  1 = result + term, 0 = result - term

Behaviour:
- Single clock domain. rst low at any time forces IDLE asynchronously, clears the term counter, and drives all outputs to 0. This includes reset mid-evaluation; there is no partial-result hold.
- Moore FSM. All outputs are decoded from the registered state only, except addsub, which is decoded from state and repcnt0. All outputs not listed for a state are 0.
- IDLE: busy=0. If start=1, go to LOAD; otherwise stay.
- LOAD: ldx=1, ld1=1, ld0cnt=1. Clear the term counter. Go to MULX1.
- MULX1: xsel=1, ldt=1 (term <= x*term). Go to MULX2.
- MULX2: xsel=1, ldt=1. Go to MULC.
- MULC: rsel=1, ldt=1, inccnt=1 (term <= coeff*term; coefficient counter +1). Increment the term counter. Go to ACC.
- ACC: en=1, ldr=1, addsub=~repcnt0. The first accumulated term (repcnt=1) is therefore subtracted; terms then alternate in sign. Go to CHECK.
- CHECK: no strobes.
  - If TLTY=0, go to DONE.
  - Else if the term counter equals MAX_TERMS, go to DONE.
  - Else go to MULX1.
- DONE: done=1, busy=0. Go to IDLE unconditionally. A start seen in DONE is ignored; the host must present start again in IDLE.
- The ld0cnt/inccnt and ldt/ld1 strobes are never asserted together. The datapath gives ldt priority over ld1; the controller must not rely on that priority.
- Start is ignored in every state except IDLE; there is no queueing and no abort input.
- Latency from the start-sampling edge to done high:
  - 7 cycles with a single term (LOAD + 5-cycle term loop + DONE).
  - +5 cycles per additional term.
  - Worst case 1 + 5*MAX_TERMS + 1 = 32 cycles at the default.
- The term counter saturates logically at MAX_TERMS; it never wraps within one evaluation.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, state IDLE; release -> LOAD on the first edge with start=1, strobes ldx=ld1=ld0cnt=1 for exactly one cycle.
- Single term: start pulse, TLTY=0 at CHECK -> state trace LOAD, MULX1, MULX2, MULC, ACC, CHECK, DONE; done high exactly at cycle 7 after start; in ACC addsub=0 with repcnt0=1.
- Max terms: TLTY held 1, repcnt0 toggled by a counter model -> exactly 6 inccnt pulses, 6 ldr pulses, addsub sequence 0,1,0,1,0,1, done at cycle 32, then IDLE.
- Early exit: TLTY=1 for the first 2 CHECKs, 0 on the 3rd -> done at cycle 17, 3 ldr pulses.
- Start while busy: start held high throughout an evaluation -> no restart mid-run; a new LOAD only on the cycle after DONE returns to IDLE with start still 1.
- Reset mid-run: rst=0 during MULC of term 2 -> outputs 0 immediately (asynchronous); after release plus start, a full evaluation starts from LOAD with the term counter at 0.
